lane_obstacle_engine: RTL and testbench

//  Parametrised multi-lane obstacle engine for the Frogger playfield; replaces the single hard-wired car.

---
 rtl/lane_obstacle_engine_pkg.sv | 37 +++
 rtl/lane_obstacle_engine_lane_mover.sv | 56 +++++
 rtl/lane_obstacle_engine.sv | 127 ++++++++++++
 tb/tb_lane_obstacle_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lane_obstacle_engine_pkg.sv
// Shared playfield constants and the lane occupancy helper for the
// Frogger obstacle engine.
package lane_obstacle_engine_pkg;

  localparam int GAME_WIDTH_DEF  = 20;
  localparam int GAME_HEIGHT_DEF = 15;
  localparam int TILE_SIZE       = 32;

  localparam logic KIND_CAR  = 1'b0;
  localparam logic KIND_LOG  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // True when column x lies inside the object whose head is at `head`.
  // The object trails behind the head, so the distance is measured against
  // the direction of motion and wrapped explicitly at the playfield width.
  // Columns at or beyond the playfield width are never covered.
  function automatic logic tile_covered(
    input logic [5:0] head,
    input logic [5:0] x,
    input logic       dir,
    input logic [2:0] len,
    input logic [5:0] width
  );
    logic [6:0] d;
    d = '0;
    if (dir == DIR_RIGHT) begin
      if (head >= x) d = {1'b0, head} - {1'b0, x};
      else           d = {1'b0, head} + {1'b0, width} - {1'b0, x};
    end else begin
      if (x >= head) d = {1'b0, x} - {1'b0, head};
      else           d = {1'b0, x} + {1'b0, width} - {1'b0, head};
    end
    tile_covered = (x < width) && (d < {4'b0000, len});
  endfunction

endpackage

// File: rtl/lane_obstacle_engine_lane_mover.sv
// One moving lane: period counter, wrapping head register and a step
// strobe that is high in the cycle the head is about to move.
module lane_mover
  import lane_obstacle_engine_pkg::*;
#(
  parameter int         GAME_WIDTH = 20,
  parameter logic       DIR        = 1'b0,
  parameter logic [3:0] PERIOD     = 4'd1,
  parameter logic [5:0] INIT_X     = 6'd0
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       tick_i,
  output logic [5:0] head_o,
  output logic       step_o
);

  // A period of zero behaves like one: step on every base tick.
  localparam logic [3:0] EFF_PERIOD  = (PERIOD == 4'd0) ? 4'd1 : PERIOD;
  localparam logic [3:0] PERIOD_LAST = EFF_PERIOD - 4'd1;
  localparam logic [5:0] LAST_COL    = 6'(GAME_WIDTH - 1);

  logic [3:0] cnt_q, cnt_d;
  logic [5:0] head_q, head_d;

  assign step_o = tick_i && (cnt_q == PERIOD_LAST);
  assign head_o = head_q;

  // Next-state: advance the period counter on each tick, step the head
  // with wrap-around when the counter completes.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    if (tick_i) begin
      if (cnt_q == PERIOD_LAST) begin
        cnt_d = 4'd0;
        if (DIR == DIR_RIGHT) head_d = (head_q == LAST_COL) ? 6'd0 : head_q + 6'd1;
        else                  head_d = (head_q == 6'd0) ? LAST_COL : head_q - 6'd1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q  <= 4'd0;
      head_q <= INIT_X;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/lane_obstacle_engine.sv
// Multi-lane obstacle engine: base-tick prescaler, one lane_mover per lane,
// combinational tile query for the renderer and registered frog
// hit / drown / drift evaluation.
module lane_obstacle_engine
  import lane_obstacle_engine_pkg::*;
#(
  parameter int                      NUM_LANES    = 8,
  parameter int                      GAME_WIDTH   = GAME_WIDTH_DEF,
  parameter int                      GAME_HEIGHT  = GAME_HEIGHT_DEF,
  parameter int                      FIRST_LANE_Y = 1,
  parameter int                      TICK_DIV     = 10000000,
  parameter logic [NUM_LANES-1:0]    LANE_DIR     = '0,
  parameter logic [NUM_LANES-1:0]    LANE_KIND    = '0,
  parameter logic [4*NUM_LANES-1:0]  LANE_PERIOD  = {NUM_LANES{4'd1}},
  parameter logic [3*NUM_LANES-1:0]  LANE_LEN     = {NUM_LANES{3'd1}},
  parameter logic [6*NUM_LANES-1:0]  LANE_INIT_X  = '0
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Enable,
  input  logic [4:0]             i_Col_Count_Div,
  input  logic [4:0]             i_Row_Count_Div,
  input  logic [5:0]             i_Frogger_X,
  input  logic [5:0]             i_Frogger_Y,
  output logic                   o_Pixel_Obj,
  output logic                   o_Pixel_Kind,
  output logic                   o_Hit,
  output logic                   o_Drowned,
  output logic                   o_Drift_Req,
  output logic                   o_Drift_Dir,
  output logic [6*NUM_LANES-1:0] o_Lane_X
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic [NUM_LANES-1:0] q_row, q_cov;
  logic [NUM_LANES-1:0] frog_row, frog_cov, lane_step;
  logic [5:0]           head [NUM_LANES];

  logic hit_q, hit_d;
  logic drowned_q, drowned_d;
  logic drift_q, drift_d;
  logic drift_dir_q, drift_dir_d;

  // Tick is only produced while running, so every lane freezes with it.
  assign tick = i_Enable && (presc_q == PRESC_LAST);

  // Prescaler next state: hold when disabled, wrap after the tick.
  always_comb begin
    presc_d = presc_q;
    if (i_Enable) presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [5:0] LANE_ROW = 6'(FIRST_LANE_Y + gi);
      // A lane placed below the playfield can never be seen or hit.
      localparam bit IN_FIELD = (FIRST_LANE_Y + gi) < GAME_HEIGHT;

      lane_mover #(
        .GAME_WIDTH (GAME_WIDTH),
        .DIR        (LANE_DIR[gi]),
        .PERIOD     (LANE_PERIOD[4*gi +: 4]),
        .INIT_X     (LANE_INIT_X[6*gi +: 6])
      ) u_mover (
        .clk    (i_Clk),
        .srst   (i_Rst),
        .tick_i (tick),
        .head_o (head[gi]),
        .step_o (lane_step[gi])
      );

      assign o_Lane_X[6*gi +: 6] = head[gi];

      assign q_row[gi]    = IN_FIELD && ({1'b0, i_Row_Count_Div} == LANE_ROW);
      assign q_cov[gi]    = tile_covered(head[gi], {1'b0, i_Col_Count_Div}, LANE_DIR[gi],
                                         LANE_LEN[3*gi +: 3], 6'(GAME_WIDTH));
      assign frog_row[gi] = IN_FIELD && (i_Frogger_Y == LANE_ROW);
      assign frog_cov[gi] = tile_covered(head[gi], i_Frogger_X, LANE_DIR[gi],
                                         LANE_LEN[3*gi +: 3], 6'(GAME_WIDTH));
    end
  endgenerate

  // Renderer query: at most one lane matches the row, so OR-reduce.
  assign o_Pixel_Obj  = |(q_row & q_cov);
  assign o_Pixel_Kind = |(q_row & q_cov & LANE_KIND);

  // Frog evaluation against the pre-step heads of this cycle.
  always_comb begin
    hit_d       = |(frog_row & frog_cov & ~LANE_KIND);
    drowned_d   = |(frog_row & ~frog_cov & LANE_KIND);
    drift_d     = |(frog_row & frog_cov & LANE_KIND & lane_step);
    drift_dir_d = |(frog_row & frog_cov & LANE_KIND & lane_step & LANE_DIR);
  end

  // Frog status registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hit_q       <= 1'b0;
      drowned_q   <= 1'b0;
      drift_q     <= 1'b0;
      drift_dir_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      drowned_q   <= drowned_d;
      drift_q     <= drift_d;
      drift_dir_q <= drift_dir_d;
    end
  end

  assign o_Hit       = hit_q;
  assign o_Drowned   = drowned_q;
  assign o_Drift_Req = drift_q;
  assign o_Drift_Dir = drift_dir_q;

endmodule

// File: tb/tb_lane_obstacle_engine.sv
// Self-checking bench for lane_obstacle_engine with TICK_DIV=4.
module tb_lane_obstacle_engine;

  localparam int NL = 8;
  localparam logic [NL-1:0]   P_DIR    = 8'b0000_0110;
  localparam logic [NL-1:0]   P_KIND   = 8'b0000_1100;
  localparam logic [4*NL-1:0] P_PERIOD = {4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd2, 4'd3, 4'd1};
  localparam logic [3*NL-1:0] P_LEN    = {3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd3, 3'd1, 3'd2};
  localparam logic [6*NL-1:0] P_INIT   = {6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd10, 6'd0, 6'd19};
  // Heads after 16 enabled clocks from reset (lane0 3, lane1 19, lane2 8, lane3 2, others 4).
  localparam logic [6*NL-1:0] HEADS_16 = {6'd4, 6'd4, 6'd4, 6'd4, 6'd2, 6'd8, 6'd19, 6'd3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en;
  logic [4:0]      col, row;
  logic [5:0]      fx, fy;
  logic            pix_obj, pix_kind, hit, drowned, drift, drift_dir;
  logic [6*NL-1:0] lane_x;

  lane_obstacle_engine #(
    .NUM_LANES(NL), .GAME_WIDTH(20), .GAME_HEIGHT(15), .FIRST_LANE_Y(1), .TICK_DIV(4),
    .LANE_DIR(P_DIR), .LANE_KIND(P_KIND), .LANE_PERIOD(P_PERIOD),
    .LANE_LEN(P_LEN), .LANE_INIT_X(P_INIT)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
    .i_Col_Count_Div(col), .i_Row_Count_Div(row),
    .i_Frogger_X(fx), .i_Frogger_Y(fy),
    .o_Pixel_Obj(pix_obj), .o_Pixel_Kind(pix_kind),
    .o_Hit(hit), .o_Drowned(drowned),
    .o_Drift_Req(drift), .o_Drift_Dir(drift_dir),
    .o_Lane_X(lane_x)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  function automatic logic [31:0] head_of(input int k);
    head_of = 32'(lane_x[6*k +: 6]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] fx, fy;
    logic [4:0] col, row;
    logic       hit, drown, obj, kind;
  } vec_t;

  typedef struct {
    logic hit, drown;
    int   idx;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  function automatic vec_t mk(input int x, input int y, input int c, input int r,
                              input bit h, input bit d, input bit o, input bit k);
    vec_t v;
    v.fx = 6'(x); v.fy = 6'(y); v.col = 5'(c); v.row = 5'(r);
    v.hit = h; v.drown = d; v.obj = o; v.kind = k;
    return v;
  endfunction

  task automatic pop_compare();
    exp_t e;
    e = sb.pop_front();
    check($sformatf("vec%0d hit", e.idx), 32'(hit), 32'(e.hit));
    check($sformatf("vec%0d drowned", e.idx), 32'(drowned), 32'(e.drown));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Frozen heads at reset: lane0 19 R car len2, lane1 0 L car len1,
    // lane2 10 L log len3, lane3 2 R log len7, lanes4-7 0 R car len1.
    //              frog     query    hit drn obj kind
    vecs[0]  = mk(19, 1, 18, 1, 1, 0, 1, 0);
    vecs[1]  = mk(18, 1, 17, 1, 1, 0, 0, 0);
    vecs[2]  = mk(17, 1,  0, 1, 0, 0, 0, 0);
    vecs[3]  = mk( 0, 2,  0, 2, 1, 0, 1, 0);
    vecs[4]  = mk( 1, 2, 19, 2, 0, 0, 0, 0);
    vecs[5]  = mk(11, 3, 12, 3, 0, 0, 1, 1);
    vecs[6]  = mk(14, 3,  9, 3, 0, 1, 0, 0);
    vecs[7]  = mk(13, 3, 10, 3, 0, 1, 1, 1);
    vecs[8]  = mk(16, 4, 19, 4, 0, 0, 1, 1);
    vecs[9]  = mk( 3, 4, 15, 4, 0, 1, 0, 0);
    vecs[10] = mk( 0, 0,  0, 0, 0, 0, 0, 0);
    vecs[11] = mk( 0, 9,  0, 9, 0, 0, 0, 0);
    vecs[12] = mk( 0, 8,  0, 8, 1, 0, 1, 0);
    vecs[13] = mk( 0, 5,  1, 5, 1, 0, 0, 0);

    rst = 1'b1; en = 1'b0; col = '0; row = '0; fx = '0; fy = '0;
    step(2);
    for (int k = 0; k < NL; k++)
      check($sformatf("reset lane%0d head", k), head_of(k), 32'(P_INIT[6*k +: 6]));
    check("reset hit", 32'(hit), 0);
    check("reset drowned", 32'(drowned), 0);
    check("reset drift_req", 32'(drift), 0);
    check("reset drift_dir", 32'(drift_dir), 0);
    rst = 1'b0;

    // Table phase with motion frozen.
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) pop_compare();
      fx = vecs[i].fx; fy = vecs[i].fy; col = vecs[i].col; row = vecs[i].row;
      #1;
      check($sformatf("vec%0d pixel_obj", i), 32'(pix_obj), 32'(vecs[i].obj));
      check($sformatf("vec%0d pixel_kind", i), 32'(pix_kind), 32'(vecs[i].kind));
      e.hit = vecs[i].hit; e.drown = vecs[i].drown; e.idx = i;
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() > 0) pop_compare();
    else check("scoreboard drained early", 1, 0);

    // Reset in the middle of a prescaler count.
    fx = 6'd0; fy = 6'd0; en = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    check("t3 lane0 partial count discarded", head_of(0), 19);
    step(1);
    check("t4 lane0 right wrap", head_of(0), 0);
    check("t4 lane1 unchanged", head_of(1), 0);
    check("t4 lane4 period0 as 1", head_of(4), 1);
    step(4);
    check("t8 lane0", head_of(0), 1);
    check("t8 lane1 not yet", head_of(1), 0);
    check("t8 lane2 left step", head_of(2), 9);
    step(4);
    check("t12 lane0", head_of(0), 2);
    check("t12 lane1 left wrap", head_of(1), 19);

    // Frog rides the log in lane 2 (head 9 covers 9..11); step at clock 16.
    fx = 6'd10; fy = 6'd3;
    step(1);
    check("t13 drowned on log", 32'(drowned), 0);
    check("t13 drift", 32'(drift), 0);
    step(1);
    check("t14 drift", 32'(drift), 0);
    step(1);
    check("t15 drift", 32'(drift), 0);
    step(1);
    check("t16 drift pulse", 32'(drift), 1);
    check("t16 drift dir", 32'(drift_dir), 1);
    check("t16 lane2 head", head_of(2), 8);
    step(1);
    check("t17 drift ended", 32'(drift), 0);
    check("t17 drowned", 32'(drowned), 0);

    // Freeze for 20 clocks; prescaler holds at 1.
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("freeze%0d lane_x", i), 32'(lane_x == HEADS_16), 1);
      check($sformatf("freeze%0d drift", i), 32'(drift), 0);
      if (i == 5) check("freeze drowned off log", 32'(drowned), 1);
      if (i == 6) check("freeze back on log", 32'(drowned), 0);
      if (i == 4) begin fx = 6'd14; fy = 6'd3; end
      if (i == 5) begin fx = 6'd9;  fy = 6'd3; end
    end

    // Resume: prescaler 1 -> tick on the third enabled clock.
    en = 1'b1;
    step(2);
    check("resume2 lane0 held", head_of(0), 3);
    step(1);
    check("resume3 lane0", head_of(0), 4);
    check("resume3 lane1", head_of(1), 19);
    check("resume3 drift", 32'(drift), 0);
    step(4);
    check("resume7 lane0", head_of(0), 5);
    check("resume7 lane1", head_of(1), 18);
    check("resume7 lane2", head_of(2), 7);
    check("resume7 drift pulse", 32'(drift), 1);
    check("resume7 drift dir", 32'(drift_dir), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
